i2c_master: RTL
===============

I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h42: 7-bit slave device address sent in the first byte.
REQ-002 SHALL have parameter QDIV, default 4: CLK cycles per SCL quarter-period, legal range 1..255.
REQ-003 SHALL have the ports listed below; the block uses one clock, and reset is synchronous and active-high.
- CLK  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- start  input  1  transaction request; sampled only in IDLE.
- RNW  input  1  1 = read, 0 = write; latched on accept.
- ADDR  input  8  register address byte; latched on accept.
- WR_DATA  input  16  write data, sent MSB byte first; latched on accept.
- RD_DATA  output  16  last successfully read data.
- busy  output  1  high from the accepted start until done.
- done  output  1  one-cycle completion pulse.
- ack_err  output  1  a NACK was received in the last transaction.
- SCL  output  1  I2C clock to the slave SCL input.
- oSDA  output  1  master data to the slave iSDA input; 1 = released.
- iSDA  input  1  slave data from the slave oSDA output.

Function
REQ-004 SHALL implement states IDLE, START, BYTE, ACK, STOP.
REQ-005 In IDLE, SCL SHALL be 1 and oSDA SHALL be 1.
REQ-006 When start=1 in IDLE, the block SHALL latch RNW, ADDR and WR_DATA, clear ack_err, set busy=1 and enter START on the next edge.
REQ-007 start SHALL be ignored while busy=1.
REQ-008 A quarter SHALL be QDIV CLK cycles, timed by an internal counter.
REQ-009 START SHALL last 2 quarters: Q0 SCL=1, oSDA=1; Q1 SCL=1, oSDA=0.
REQ-010 Each bit in BYTE or ACK SHALL last 4 quarters: Q0–Q1 SCL=0, with oSDA updated at the start of Q0; Q2–Q3 SCL=1.
REQ-011 iSDA SHALL be sampled on the last CLK cycle of Q2 of each bit.
REQ-012 A transaction SHALL send or receive 4 bytes, MSB first, each byte followed by one ACK bit:
- byte 0 = {DEV_ADDR, RNW};
- byte 1 = ADDR;
- bytes 2–3 = WR_DATA[15:8], WR_DATA[7:0] when writing, or data from the slave when reading.
REQ-013 For master-sent bytes, oSDA SHALL be 1 during the ACK bit; a sampled iSDA=1 SHALL set ack_err=1 and go directly to STOP after that ACK bit.
REQ-014 For read bytes 2–3, oSDA SHALL be 1 during the data bits and sampled bits SHALL shift into an internal register.
- After byte 2, the master SHALL drive ACK, oSDA=0.
- After byte 3, the master SHALL drive NACK, oSDA=1.
REQ-015 STOP SHALL last 3 quarters: Q0 SCL=0, oSDA=0; Q1 SCL=1, oSDA=0; Q2 SCL=1, oSDA=1.
REQ-016 On the edge that ends STOP Q2, the block SHALL enter IDLE with done=1 for one cycle and busy=0; this applies to both completed and aborted transactions.
REQ-017 RD_DATA SHALL be updated with the shifted data only on done of a read with ack_err=0; otherwise it SHALL hold its value.
REQ-018 Latency SHALL be fixed:
- full transaction: done asserts 1+149*QDIV cycles after the accept cycle (597 at QDIV=4);
- NACK on byte 0: done asserts after 1+41*QDIV cycles;
- NACK on byte 1: done asserts after 1+77*QDIV cycles.
REQ-019 A start asserted in the done cycle SHALL be accepted, giving back-to-back transactions.
REQ-020 Bit and byte counters SHALL be restarted at every byte; no counter SHALL wrap within a transaction.

Reset
REQ-021 Reset=1 SHALL take priority over all other inputs on every edge.
REQ-022 On reset the block SHALL enter IDLE with SCL=1, oSDA=1, busy=0, done=0, ack_err=0, RD_DATA=16'h0000, and all counters at 0.
REQ-023 Reset mid-transaction SHALL abort it without a STOP sequence and without a done pulse.

Verification
REQ-024 Write test: QDIV=4, ADDR=8'h10, WR_DATA=16'hBEEF, slave ACKs every byte -> SDA bytes 0x84, 0x10, 0xBE, 0xEF, done at cycle 597, ack_err=0.
REQ-025 Read test: ADDR=8'h05, slave returns 0x12 then 0x34 -> SDA bytes 0x85, 0x05, master ACK after 0x12, NACK after 0x34, RD_DATA=16'h1234 at done.
REQ-026 NACK test: slave NACKs byte 0 -> ack_err=1, STOP immediately after the first ACK bit, done at cycle 165, RD_DATA unchanged.
REQ-027 Reset test: Reset pulsed during byte 2 -> next cycle SCL=1, oSDA=1, busy=0, no done pulse; a following write completes normally.
REQ-028 Handshake test: start pulsed while busy is ignored; start held high through done -> a second transaction begins, with START Q0 on the cycle after done.
REQ-029 Timing test: QDIV=1 -> every SCL-high and SCL-low phase is exactly 2 cycles, and iSDA is sampled on the first SCL-high cycle.

Source files
------------

// File: rtl/i2c_master.sv
// I2C write/read master for a fixed-address register-mapped slave.
// Each transaction is 4 bytes: {DEV_ADDR,RNW}, ADDR, then two data bytes
// that are written from WR_DATA or read back into RD_DATA.
// Ports:
//   CLK, Reset       - clock and synchronous active-high reset
//   start            - request, accepted only while idle
//   RNW/ADDR/WR_DATA - transaction descriptor, latched on accept
//   RD_DATA          - data of the last error-free read
//   busy, done       - in-flight flag and one-cycle completion pulse
//   ack_err          - a NACK was seen on a master-sent byte
//   SCL, oSDA, iSDA  - bus clock, master data out (1 = released), slave data in
module i2c_master #(
  parameter logic [6:0]  DEV_ADDR = 7'h42,
  parameter int unsigned QDIV     = 4
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        start,
  input  logic        RNW,
  input  logic [7:0]  ADDR,
  input  logic [15:0] WR_DATA,
  output logic [15:0] RD_DATA,
  output logic        busy,
  output logic        done,
  output logic        ack_err,
  output logic        SCL,
  output logic        oSDA,
  input  logic        iSDA
);

  localparam int unsigned QW = 8;

  typedef enum logic [2:0] {IDLE, START, BYTE, ACK, STOP} state_t;

  state_t       state;
  logic [QW-1:0] qCnt;
  logic [1:0]   quarter;
  logic [2:0]   bitCnt;
  logic [1:0]   byteCnt;
  logic         rnwReg;
  logic [7:0]   addrReg;
  logic [15:0]  wrReg;
  logic [7:0]   txShift;
  logic [15:0]  rxShift;
  logic [7:0]   nextByte;
  logic         qEnd;
  logic         rdByte;
  logic         nextRead;

  // Last CLK cycle of the current quarter
  assign qEnd = (qCnt == QW'(QDIV - 1));
  // Data bytes of a read are driven by the slave
  assign rdByte   = rnwReg && byteCnt[1];
  assign nextRead = rnwReg && (byteCnt != 2'd0);

  // Master-sent byte that follows the current one
  always_comb begin
    nextByte = wrReg[7:0];
    case (byteCnt)
      2'd0:    nextByte = addrReg;
      2'd1:    nextByte = wrReg[15:8];
      default: nextByte = wrReg[7:0];
    endcase
  end

  // Transaction sequencer; bus lines change only at quarter boundaries
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state   <= IDLE;
      qCnt    <= '0;
      quarter <= '0;
      bitCnt  <= '0;
      byteCnt <= '0;
      rnwReg  <= 1'b0;
      addrReg <= '0;
      wrReg   <= '0;
      txShift <= '0;
      rxShift <= '0;
      RD_DATA <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      SCL     <= 1'b1;
      oSDA    <= 1'b1;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        qCnt    <= '0;
        quarter <= '0;
        if (start) begin
          rnwReg  <= RNW;
          addrReg <= ADDR;
          wrReg   <= WR_DATA;
          ack_err <= 1'b0;
          busy    <= 1'b1;
          state   <= START;
        end
      end else if (!qEnd) begin
        qCnt <= qCnt + QW'(1);
      end else begin
        qCnt    <= '0;
        quarter <= quarter + 2'd1;
        case (state)
          START: begin
            if (quarter == 2'd0) begin
              oSDA <= 1'b0;
            end else begin
              state   <= BYTE;
              quarter <= '0;
              bitCnt  <= '0;
              byteCnt <= '0;
              SCL     <= 1'b0;
              oSDA    <= DEV_ADDR[6];
              txShift <= {DEV_ADDR[5:0], rnwReg, 1'b0};
            end
          end
          BYTE, ACK: begin
            case (quarter)
              2'd1: SCL <= 1'b1;
              2'd2: begin
                if (state == BYTE && rdByte) rxShift <= {rxShift[14:0], iSDA};
                if (state == ACK && !rdByte && iSDA) ack_err <= 1'b1;
              end
              2'd3: begin
                SCL     <= 1'b0;
                quarter <= '0;
                if (state == BYTE) begin
                  if (bitCnt != 3'd7) begin
                    bitCnt  <= bitCnt + 3'd1;
                    oSDA    <= rdByte ? 1'b1 : txShift[7];
                    txShift <= {txShift[6:0], 1'b0};
                  end else begin
                    // Read data: ACK after byte 2, NACK after the last byte
                    state  <= ACK;
                    bitCnt <= '0;
                    oSDA   <= rdByte ? (byteCnt == 2'd3) : 1'b1;
                  end
                end else if (ack_err || byteCnt == 2'd3) begin
                  state <= STOP;
                  oSDA  <= 1'b0;
                end else begin
                  state   <= BYTE;
                  byteCnt <= byteCnt + 2'd1;
                  oSDA    <= nextRead ? 1'b1 : nextByte[7];
                  txShift <= {nextByte[6:0], 1'b0};
                end
              end
              default: ;
            endcase
          end
          STOP: begin
            if (quarter == 2'd0) begin
              SCL <= 1'b1;
            end else if (quarter == 2'd1) begin
              oSDA <= 1'b1;
            end else begin
              state   <= IDLE;
              quarter <= '0;
              byteCnt <= '0;
              busy    <= 1'b0;
              done    <= 1'b1;
              if (rnwReg && !ack_err) RD_DATA <= rxShift;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
